// File: rtl/mau_pkg.sv
// Shared encodings and alignment helpers for the memory access unit.
package mau_pkg;

  typedef enum logic [1:0] {
    DT_WORD     = 2'b00,
    DT_HALF     = 2'b01,
    DT_BYTE     = 2'b10,
    DT_WORD_ALT = 2'b11
  } data_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    DATA = 2'b10,
    WR   = 2'b11
  } state_t;

  function automatic logic is_word(input data_type_t dt);
    return (dt == DT_WORD) || (dt == DT_WORD_ALT);
  endfunction

  function automatic logic is_misaligned(input data_type_t dt, input logic [1:0] lo);
    logic m;
    case (dt)
      DT_HALF: m = lo[0];
      DT_BYTE: m = 1'b0;
      default: m = (lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: zero-extended load extract and sub-word store merge.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  data_type_t  data_type,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  // Little-endian lane selection; bit offset is the byte offset times 8.
  always_comb begin
    load_data  = 32'h0000_0000;
    store_data = word;
    case (data_type)
      DT_HALF: begin
        load_data[15:0]                        = word[{addr_lo[1], 4'b0000} +: 16];
        store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      DT_BYTE: begin
        load_data[7:0]                      = word[{addr_lo, 3'b000} +: 8];
        store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller for a word-wide RAM with posedge-registered read and
// negedge write; sub-word stores use read-modify-write, loads zero-extend.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            data_type,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_t                state;
  data_type_t            dt_in;
  data_type_t            dt_r;
  logic                  wr_r;
  logic [1:0]            addr_lo_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_data;

  assign dt_in = data_type_t'(data_type);

  mau_lane_align u_align (
    .word       (mem_q),
    .wdata      (wdata_r),
    .addr_lo    (addr_lo_r),
    .data_type  (dt_r),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // mem_we is set only on entry to WR and cleared on exit, so reset kills it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_we         <= 1'b0;
      rdata          <= '0;
      mem_data       <= '0;
      mem_read_addr  <= '0;
      mem_write_addr <= '0;
      wr_r           <= 1'b0;
      dt_r           <= DT_WORD;
      addr_lo_r      <= 2'b00;
      wdata_r        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (is_misaligned(dt_in, addr[1:0])) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              wr_r           <= wr;
              dt_r           <= dt_in;
              addr_lo_r      <= addr[1:0];
              wdata_r        <= wdata;
              mem_read_addr  <= addr[ADDR_WIDTH+1:2];
              mem_write_addr <= addr[ADDR_WIDTH+1:2];
              busy           <= 1'b1;
              if (wr && is_word(dt_in)) begin
                state    <= WR;
                mem_we   <= 1'b1;
                mem_data <= wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          state <= DATA;
        end
        DATA: begin
          if (wr_r) begin
            mem_data <= store_data;
            mem_we   <= 1'b1;
            state    <= WR;
          end else begin
            rdata <= load_data;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WR: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store controller that drives the word-wide data RAM (separate read/write address, negedge-write, posedge-registered read).
- Converts byte-addressed word, halfword and byte requests into RAM word accesses.
- Sub-word stores use read-modify-write; loads zero-extend.
- Sits between the datapath load/store path and the data RAM.

Parameters:
- ADDR_WIDTH, 4, RAM word-address width; the byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, RAM word width; fixed at 32 for this block.

Ports:
- clk  in  1  single system clock; this block uses posedge only.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request, sampled only in IDLE.
- wr  in  1  1 = store, 0 = load; sampled with req.
- data_type  in  2  00/11 word, 01 halfword, 10 byte.
- addr  in  ADDR_WIDTH+2  byte address.
- wdata  in  32  store data, right-aligned.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned flag; valid only when done=1.
- rdata  out  32  load result, zero-extended; holds until the next load completes.
- mem_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- mem_write_addr  out  ADDR_WIDTH  to RAM write_addr.
- mem_we  out  1  to RAM we.
- mem_data  out  32  to RAM data.
- mem_q  in  32  from RAM q.

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - busy, done, err, mem_we = 0.
  - rdata, mem_data, mem_read_addr, mem_write_addr = 0.
  - Any in-flight access is aborted; an aborted WR never writes.
- Accept: at a posedge with state IDLE and req=1, latch wr, data_type, addr and wdata. Requests while busy are ignored and not queued.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always aligned.
  - On misalign: stay IDLE, and on the next cycle done=1 with err=1. No RAM access; rdata is unchanged.
- Word address = addr[ADDR_WIDTH+1:2]. It drives both mem_read_addr and mem_write_addr from the accept edge until the return to IDLE.
- States: IDLE, RD, DATA, WR.
- Load (accept edge E0):
  - IDLE -> RD at E0.
  - The RAM samples the address at E1; RD -> DATA.
  - At E2, rdata is registered from mem_q using lane select, DATA -> IDLE, and done=1 for the E2..E3 cycle.
  - Load latency is 2 edges after accept; the next accept is possible at E3.
- Lane select, little-endian:
  - Byte lane n = bits 8n+7:8n.
  - Halfword uses addr[1]: 0 selects bits 15:0, 1 selects bits 31:16.
  - Byte uses addr[1:0].
  - All upper bits of rdata = 0.
- Full-word store:
  - IDLE -> WR at E0, with mem_data = wdata.
  - mem_we=1 during WR (decoded from registered state); the RAM writes on the mid-cycle negedge.
  - WR -> IDLE at E1; done=1 for the E1..E2 cycle.
- Sub-word store (read-modify-write):
  - IDLE -> RD at E0, RD -> DATA at E1.
  - At E2, mem_data = mem_q with the target lane(s) replaced by wdata[7:0] or wdata[15:0]; DATA -> WR.
  - The write happens on the negedge within WR.
  - WR -> IDLE at E3; done=1 for E3..E4.
- mem_we is 0 in every state except WR.
- The read-modify-write window is atomic: no other master shares the RAM.
- done and err are registered pulses, exactly one cycle per accepted request.
- Reset asserted in RD or DATA: no write occurs.
- Reset asserted in WR before the negedge: mem_we drops immediately and no write occurs.
- A req held high at the cycle done is high is accepted only if state is IDLE. Back-to-back accepts are spaced per the latencies above.

Decomposition:
- Shared package holds:
  - data_type encodings DT_WORD=00, DT_HALF=01, DT_BYTE=10, DT_WORD_ALT=11.
  - State encodings IDLE/RD/DATA/WR.
- One natural sub-module, mau_lane_align: purely combinational.
  - Load: extract and zero-extend from word and addr[1:0].
  - Store: merge wdata into word using addr[1:0] and data_type.
  - The FSM stays in mem_access_unit.

Test Plan:
- Full-word store then load:
  - Store addr=0x08, wdata=0xDEADBEEF -> mem_we high for exactly one cycle, ram[2]=0xDEADBEEF, done 1 cycle after accept.
  - Load of the same address -> rdata=0xDEADBEEF, done 2 cycles after accept.
- Byte store read-modify-write:
  - Preload ram[1]=0x11223344, store byte addr=0x06, wdata=0xAB -> ram[1]=0x11AB3344.
  - done 3 cycles after accept; exactly one mem_we cycle.
- Halfword load, upper lane:
  - ram[3]=0xCAFE1234, load half addr=0x0E -> rdata=0x0000CAFE.
  - Byte load addr=0x0D -> rdata=0x00000012.
- Misaligned accesses:
  - Word store addr=0x05 -> done=1 and err=1 next cycle, mem_we never asserted, RAM unchanged.
  - Half load addr=0x03 -> err=1, rdata unchanged.
- Reset mid-operation:
  - Assert rst during DATA of a byte store to addr=0x00 -> busy=0 immediately, mem_we never high, ram[0] unchanged.
  - Next request after reset completes normally.
- Busy handling:
  - Pulse req again while busy=1 -> ignored; exactly one done.
  - Hold req continuously with a sequence of 4 word loads -> 4 done pulses spaced 3 cycles apart, correct rdata each.
